// File: rtl/nibble_uart_tx_pkg.sv
// nibble_uart_tx_pkg: shared state encoding, frame constants and parity helper
package nibble_uart_tx_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;
  localparam int DATA_BITS = 4;
  function automatic int frame_bits(input bit parity_en);
    return DATA_BITS + 2 + int'(parity_en);
  endfunction
  function automatic logic parity_of(input logic [3:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction
endpackage

// File: rtl/nibble_uart_tx_if.sv
// nibble_uart_tx_if: valid/ready nibble handshake into the transmitter
interface nibble_uart_tx_if;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  modport master(output in_data, output in_valid, input in_ready);
  modport slave(input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/nibble_uart_tx_bit_timer.sv
// nibble_uart_tx_bit_timer: per-bit tick counter flagging the last clock of a bit
module nibble_uart_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  output logic last_tick_o
);
  logic [7:0] tick_q, tick_d;
  assign last_tick_o = tick_q == 8'(CLKS_PER_BIT - 1);
  // tick counter wraps on the last tick and is held at zero while cleared
  always_comb tick_d = (clr_i || last_tick_o) ? '0 : tick_q + 8'd1;
  // tick register
  always_ff @(posedge clk)
    tick_q <= reset ? '0 : tick_d;
endmodule

// File: rtl/nibble_uart_tx.sv
// nibble_uart_tx: serialises a nibble as start, 4 data bits LSB first, optional parity, stop
module nibble_uart_tx
  import nibble_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_EN    = 1'b1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  nibble_uart_tx_if.slave   in_if,
  output logic              tx,
  output logic              busy
);
  state_e     state_q, state_d;
  logic [3:0] shreg_q, shreg_d;
  logic [1:0] bit_q, bit_d;
  logic       par_q, par_d, tx_q, tx_d, last_tick, accept;
  nibble_uart_tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk,
    .reset,
    .clr_i(state_q == IDLE),
    .last_tick_o(last_tick)
  );
  assign in_if.in_ready = state_q == IDLE || (state_q == STOP && last_tick);
  assign accept = in_if.in_valid && in_if.in_ready;
  assign tx = tx_q;
  assign busy = state_q != IDLE;
  // next state; an accept in IDLE or on the final stop tick loads a new frame, and tx is precomputed from the next state
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d = bit_q;
    par_d = par_q;
    if (last_tick)
      case (state_q)
        START: state_d = DATA;
        DATA: begin
          shreg_d = shreg_q >> 1;
          bit_d = bit_q + 2'd1;
          if (bit_q == 2'(DATA_BITS - 1)) state_d = PARITY_EN ? PARITY : STOP;
        end
        PARITY: state_d = STOP;
        STOP: state_d = IDLE;
        default: state_d = state_q;
      endcase
    if (accept) begin
      state_d = START;
      shreg_d = in_if.in_data;
      bit_d = '0;
      par_d = parity_of(in_if.in_data, PARITY_ODD);
    end
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shreg_d[0] : state_d == PARITY ? par_d : 1'b1;
  end
  // state registers; reset discards any frame in progress
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bit_q <= '0;
      par_q <= 1'b0;
      tx_q <= 1'b1;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q <= bit_d;
      par_q <= par_d;
      tx_q <= tx_d;
    end
endmodule

// File: tb/tb_nibble_uart_tx.sv
// tb_nibble_uart_tx: scoreboard bench for three parity configurations of the transmitter
module tb_nibble_uart_tx;
  import nibble_uart_tx_pkg::*;
  localparam int CPB = 4;
  typedef struct {
    int         dut;
    logic [6:0] seq;
    int         nb;
    bit         b2b;
    bit         abort;
  } frame_t;
  logic clk = 1'b0, reset = 1'b1, valid = 1'b0;
  logic [3:0] data = '0;
  int sel = 0, checks = 0, errors = 0;
  wire [2:0] txv, bsv, rdv;
  frame_t exp_q[$];
  frame_t cur[3];
  bit in_fr[3] = '{0, 0, 0};
  int cyc[3] = '{0, 0, 0};
  int gap[3] = '{1000, 1000, 1000};
  always #5 clk = ~clk;
  nibble_uart_tx_if if0 (), if1 (), if2 ();
  assign if0.in_data = data;
  assign if1.in_data = data;
  assign if2.in_data = data;
  assign if0.in_valid = valid && sel == 0;
  assign if1.in_valid = valid && sel == 1;
  assign if2.in_valid = valid && sel == 2;
  assign rdv = {if2.in_ready, if1.in_ready, if0.in_ready};
  nibble_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_even (
    .clk(clk), .reset(reset), .in_if(if0), .tx(txv[0]), .busy(bsv[0]));
  nibble_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut_odd (
    .clk(clk), .reset(reset), .in_if(if1), .tx(txv[1]), .busy(bsv[1]));
  nibble_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut_np (
    .clk(clk), .reset(reset), .in_if(if2), .tx(txv[2]), .busy(bsv[2]));
  // monitor: pops an expected frame at each start bit and checks tx/busy/in_ready every cycle
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      logic et, er;
      if (reset) begin
        if (in_fr[k]) begin
          checks++;
          if (!cur[k].abort) begin
            errors++;
            $display("FAIL abort dut%0d: frame cut by reset at cycle %0d, required a complete frame", k, cyc[k]);
          end
          in_fr[k] = 1'b0;
        end
        gap[k] = 1000;
        continue;
      end
      if (!in_fr[k] && txv[k] === 1'b0) begin
        checks++;
        if (exp_q.size() == 0 || exp_q[0].dut != k) begin
          errors++;
          $display("FAIL start dut%0d: unexpected start bit, required idle line", k);
          continue;
        end
        cur[k] = exp_q.pop_front();
        in_fr[k] = 1'b1;
        cyc[k] = 0;
        if (cur[k].b2b) begin
          checks++;
          if (gap[k] != 0) begin
            errors++;
            $display("FAIL b2b dut%0d: idle gap %0d cycles, required 0", k, gap[k]);
          end
        end
      end else if (!in_fr[k]) begin
        checks++;
        if (txv[k] !== 1'b1 || bsv[k] !== 1'b0 || rdv[k] !== 1'b1) begin
          errors++;
          $display("FAIL idle dut%0d: tx=%b busy=%b in_ready=%b, required 1 0 1", k, txv[k], bsv[k], rdv[k]);
        end
        gap[k]++;
      end
      if (in_fr[k]) begin
        et = cur[k].seq[cur[k].nb - 1 - cyc[k] / CPB];
        er = cyc[k] == cur[k].nb * CPB - 1;
        checks++;
        if (txv[k] !== et || bsv[k] !== 1'b1 || rdv[k] !== er) begin
          errors++;
          $display("FAIL frame dut%0d cycle %0d: tx=%b busy=%b in_ready=%b, required %b 1 %b",
                   k, cyc[k], txv[k], bsv[k], rdv[k], et, er);
        end
        cyc[k]++;
        if (cyc[k] == cur[k].nb * CPB) begin
          checks++;
          if (cur[k].abort) begin
            errors++;
            $display("FAIL complete dut%0d: frame ran to its stop bit, required abort by reset", k);
          end
          in_fr[k] = 1'b0;
          gap[k] = 0;
        end
      end
    end
  end
  task automatic send(input int k, input logic [3:0] d, input logic [6:0] seq, input bit b2b, input bit ab);
    frame_t f;
    logic r;
    int n;
    f.dut = k;
    f.seq = seq;
    f.nb = frame_bits(k != 2);
    f.b2b = b2b;
    f.abort = ab;
    exp_q.push_back(f);
    sel = k;
    data = d;
    valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      r = rdv[k];
      @(posedge clk);
      n++;
    end while (!r && n < 200);
    #1;
    checks++;
    if (!r) begin
      errors++;
      $display("FAIL accept dut%0d: in_ready never high in %0d cycles, required an accept", k, n);
    end
  endtask
  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || in_fr[0] || in_fr[1] || in_fr[2]) && n < 500) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL drain: %0d frames still pending, required 0", exp_q.size());
    end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    send(0, 4'hA, 7'b0010101, 1'b0, 1'b0);
    valid = 1'b0;
    drain();
    send(0, 4'h7, 7'b0111011, 1'b0, 1'b0);
    valid = 1'b0;
    drain();
    send(1, 4'h7, 7'b0111001, 1'b0, 1'b0);
    valid = 1'b0;
    drain();
    send(2, 4'h7, 7'b0011101, 1'b0, 1'b0);
    valid = 1'b0;
    drain();
    send(0, 4'h3, 7'b0110001, 1'b0, 1'b0);
    send(0, 4'hC, 7'b0001101, 1'b1, 1'b0);
    valid = 1'b0;
    drain();
    send(0, 4'h6, 7'b0011001, 1'b0, 1'b0);
    valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    data = 4'h5;
    valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    drain();
    repeat (10) @(posedge clk);
    #1;
    send(0, 4'hF, 7'b0111101, 1'b0, 1'b1);
    valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    checks += 2;
    if (txv[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_tx: tx=%b, required 1", txv[0]);
    end
    if (bsv[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: busy=%b, required 0", bsv[0]);
    end
    reset = 1'b0;
    send(0, 4'h9, 7'b0100101, 1'b0, 1'b0);
    valid = 1'b0;
    drain();
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d expected frames unsent, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
